// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hold/flush/redirect sequencer with event counters and stall watchdog
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int HOLD_TIMEOUT = 1024,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jump_en_i,
  input  logic [31:0]      jump_addr_i,
  input  logic             hold_ex_i,
  input  logic             hold_if_i,
  output logic             jump_en_o,
  output logic [31:0]      jump_addr_o,
  output logic             hold_pc_o,
  output logic             hold_if_id_o,
  output logic             flush_if_id_o,
  output logic             hold_id_ex_o,
  output logic             flush_id_ex_o,
  output logic [1:0]       state_o,
  output logic             hang_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] redir_cnt_o
);

  localparam logic [1:0]  ST_RUN   = 2'd0;
  localparam logic [1:0]  ST_FLUSH = 2'd1;
  localparam logic [1:0]  ST_STALL = 2'd2;
  localparam logic [3:0]  SHADOW_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [15:0] WD_LIMIT    = 16'(HOLD_TIMEOUT);

  logic [1:0]       state_q, state_d;
  logic [3:0]       shadow_q, shadow_d;
  logic [15:0]      wdog_q, wdog_d;
  logic             hang_q, hang_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;

  always_comb begin
    jump_en_o     = 1'b0;
    jump_addr_o   = 32'h0;
    hold_pc_o     = 1'b0;
    hold_if_id_o  = 1'b0;
    flush_if_id_o = 1'b0;
    hold_id_ex_o  = 1'b0;
    flush_id_ex_o = 1'b0;
    state_d       = state_q;
    shadow_d      = shadow_q;

    if (rst) begin
      state_d  = ST_RUN;
      shadow_d = 4'd0;
    end else if (jump_en_i) begin
      jump_en_o     = 1'b1;
      jump_addr_o   = jump_addr_i;
      flush_if_id_o = 1'b1;
      flush_id_ex_o = 1'b1;
      shadow_d      = SHADOW_INIT;
      state_d       = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
    end else if (hold_ex_i) begin
      hold_pc_o    = 1'b1;
      hold_if_id_o = 1'b1;
      hold_id_ex_o = 1'b1;
      // A stall inside the flush shadow freezes the shadow rather than leaving FLUSH.
      state_d      = (state_q == ST_FLUSH) ? ST_FLUSH : ST_STALL;
    end else begin
      if (hold_if_i) begin
        hold_pc_o     = 1'b1;
        flush_if_id_o = 1'b1;
      end
      if (state_q == ST_FLUSH) begin
        flush_if_id_o = 1'b1;
        shadow_d      = (shadow_q != 4'd0) ? shadow_q - 4'd1 : 4'd0;
        state_d       = (shadow_q <= 4'd1) ? ST_RUN : ST_FLUSH;
      end else begin
        state_d = ST_RUN;
      end
    end
  end

  always_comb begin
    wdog_d      = 16'd0;
    hang_d      = hang_q;
    stall_cnt_d = stall_cnt_q;
    redir_cnt_d = redir_cnt_q;
    if (hold_ex_i && !jump_en_i) begin
      wdog_d = (wdog_q >= WD_LIMIT) ? wdog_q : wdog_q + 16'd1;
    end
    if (wdog_d == WD_LIMIT) begin
      hang_d = 1'b1;
    end
    if (hold_pc_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (jump_en_o && (redir_cnt_q != {CNT_W{1'b1}})) begin
      redir_cnt_d = redir_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      shadow_q    <= 4'd0;
      wdog_q      <= 16'd0;
      hang_q      <= 1'b0;
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      wdog_q      <= wdog_d;
      hang_q      <= hang_d;
      stall_cnt_q <= stall_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign state_o     = state_q;
  assign hang_o      = hang_q;
  assign stall_cnt_o = stall_cnt_q;
  assign redir_cnt_o = redir_cnt_q;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline control unit for the 3-stage core (if_id -> id -> id_ex -> ex).
- Sequences PC redirects, bubble insertion and stalls. It drives hold/flush into pc_reg, if_id and id_ex, so the decode datapath only ever sees valid instructions or zero-bubbles.
- Tracks flush-shadow cycles after a redirect with a small FSM.
- Provides saturating stall/redirect event counters and a stall watchdog.

Parameters:
- FLUSH_CYCLES, 2: cycles if_id is flushed per redirect, counting the redirect cycle; legal range 1..15.
- HOLD_TIMEOUT, 1024: consecutive hold_ex_i cycles after which hang_o sets; legal range 1..65535.
- CNT_W, 32: width of the event counters.

Ports:
- clk, input, 1: core clock.
- rst, input, 1: synchronous, active-high reset.
- jump_en_i, input, 1: ex-stage redirect (taken branch/jal/jalr), one-cycle pulse.
- jump_addr_i, input, 32: redirect target.
- hold_ex_i, input, 1: ex busy with a multi-cycle op (level).
- hold_if_i, input, 1: fetch data not ready this cycle (level).
- jump_en_o, output, 1: redirect to pc_reg.
- jump_addr_o, output, 32: redirect target to pc_reg.
- hold_pc_o, output, 1: pc_reg keeps its value.
- hold_if_id_o, output, 1: if_id keeps its contents.
- flush_if_id_o, output, 1: if_id loads a NOP bubble (inst 0x00000013, addr 0).
- hold_id_ex_o, output, 1: id_ex keeps its contents.
- flush_id_ex_o, output, 1: id_ex loads a bubble (reg_wen 0, rd 0).
- state_o, output, 2: FSM state (RUN=0, FLUSH=1, STALL=2).
- hang_o, output, 1: sticky watchdog flag.
- stall_cnt_o, output, CNT_W: cycles with hold_pc_o=1.
- redir_cnt_o, output, CNT_W: accepted redirects.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state <- RUN, shadow counter <- 0, watchdog counter <- 0.
  - hang_o <- 0, both event counters <- 0.
  - While rst=1, all combinational outputs are 0, and jump_addr_o is 0.
  - Reset mid-FLUSH or mid-STALL abandons the operation immediately; no residual flush follows.
- Outputs are combinational from the current state and the inputs (zero latency). The state, counters and hang_o are registered.
- Priority per cycle: jump_en_i > hold_ex_i > hold_if_i > FLUSH state > idle.
- Redirect cycle (jump_en_i=1):
  - jump_en_o=1, jump_addr_o=jump_addr_i, flush_if_id_o=1, flush_id_ex_o=1; all holds 0.
  - Accepted in any state.
  - If FLUSH_CYCLES>1: shadow <- FLUSH_CYCLES-1, next state FLUSH. Otherwise next state RUN.
  - redir_cnt_o increments.
  - A redirect during FLUSH reloads the shadow counter (restart). A redirect during STALL aborts the stall.
- Otherwise, jump_addr_o=0 and jump_en_o=0.
- hold_ex_i=1 (no jump):
  - hold_pc_o=1, hold_if_id_o=1, hold_id_ex_o=1; both flushes 0.
  - From RUN/STALL, next state is STALL.
  - In FLUSH, the state stays FLUSH and the shadow counter freezes.
- hold_if_i=1 (no jump, no hold_ex_i):
  - hold_pc_o=1, flush_if_id_o=1, id_ex advances.
  - In FLUSH, the shadow counter still decrements.
  - From STALL, next state is RUN.
- FLUSH with no hold_ex_i:
  - flush_if_id_o=1 and the shadow counter decrements.
  - When the shadow counter is 1, next state is RUN.
  - Result: exactly FLUSH_CYCLES-1 shadow cycles after the redirect cycle, provided there is no hold_ex_i.
- STALL with hold_ex_i=0 (no jump): next state RUN; outputs are idle (all 0) unless hold_if_i=1.
- Idle (RUN, no request): all control outputs 0.
- Watchdog:
  - The counter increments while hold_ex_i=1 and jump_en_i=0, and clears otherwise.
  - When it reaches HOLD_TIMEOUT, hang_o <- 1 and stays 1 until rst.
  - The watchdog does not alter the pipeline controls.
- Event counters:
  - stall_cnt_o increments each cycle hold_pc_o=1.
  - Both counters saturate at all-ones and never wrap.
- Invariants (assert in the bench):
  - hold_X and flush_X are never both 1 for the same register.
  - jump_en_o implies both flushes are 1.

Test Plan:
- Reset, then an idle RUN cycle -> all control outputs 0, state_o=0, counters 0, hang_o 0.
- jump_en_i pulse, addr 0x00000080, FLUSH_CYCLES=2 -> cycle0: jump_en_o=1, addr 0x80, both flushes 1; cycle1: state FLUSH, flush_if_id_o=1 only; cycle2: RUN, idle; redir_cnt_o=1.
- hold_ex_i high 3 cycles, starting from RUN -> pc/if_id/id_ex holds 1 for exactly those 3 cycles; state STALL for 3 cycles, then RUN; stall_cnt_o=3.
- Redirect, then hold_ex_i during the FLUSH cycle for 2 cycles -> shadow frozen, holds 1, flush_if_id_o 0; after hold_ex_i drops, one more flush_if_id_o=1 cycle, then RUN.
- hold_if_i for 1 cycle simultaneous with jump_en_i -> jump wins: no hold_pc_o, both flushes 1.
- HOLD_TIMEOUT=4, hold_ex_i high 6 cycles -> hang_o rises after the 4th cycle and stays 1 after hold_ex_i drops; rst clears it.
